// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS instruction-fetch slice.
//   ADDR_W / INSTR_W : byte-address and instruction widths
//   RESET_PC         : default first fetch address after reset
//   MIPS_NOP         : canonical no-op encoding (sll $0,$0,0)
//   fetch_entry_t    : {pc, instr} pair carried from fetch to decode
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] MIPS_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Prefetch FIFO of fetch_entry_t with a registered head slot.
// The head register is what decode sees; the backing array holds the rest.
// Ports:
//   clk, rst_ni        : clock, asynchronous active-low reset
//   flush_i            : synchronous flush (wins over a same-cycle push)
//   push_i/push_data_i : write one entry
//   pop_i              : consume the head (ignored when head is empty)
//   head_valid_o       : head slot holds an entry
//   head_data_o        : head entry (registered, zero after reset)
//   count_o            : total entries held (head + backing)
// ---------------------------------------------------------------------------
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output logic                       head_valid_o,
  output fetch_entry_t               head_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t      mem [DEPTH];
  fetch_entry_t      head_q, head_d;
  logic              head_valid_q, head_valid_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     bcount_q, bcount_d;

  logic pop;
  logic head_free;
  logic bk_empty;
  logic refill_from_bk;
  logic push_to_head;
  logic push_to_bk;

  assign pop       = pop_i && head_valid_q;
  assign head_free = !head_valid_q || pop;
  assign bk_empty  = (bcount_q == '0);

  // The head is refilled from the backing store first so ordering is kept;
  // a push only bypasses straight into the head when nothing older is waiting.
  assign refill_from_bk = head_free && !bk_empty;
  assign push_to_head   = head_free && bk_empty && push_i;
  assign push_to_bk     = push_i && !push_to_head;

  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    bcount_d     = bcount_q + CW'(push_to_bk) - CW'(refill_from_bk);

    if (refill_from_bk) begin
      head_d       = mem[rd_ptr_q];
      head_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + PW'(1);
    end else if (push_to_head) begin
      head_d       = push_data_i;
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end

    if (push_to_bk) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    // Flush is evaluated after the pop so a same-cycle pop still completes.
    if (flush_i) begin
      head_valid_d = 1'b0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      bcount_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      bcount_q     <= '0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      bcount_q     <= bcount_d;
    end
  end

  // Backing storage: no reset, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_to_bk && !flush_i) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_q;
  assign count_o      = bcount_q + CW'(head_valid_q);

  // The fetch unit's credit scheme must never let a push land on a full queue.
  assert property (@(posedge clk) disable iff (!rst_ni)
                   !(push_i && (count_o == CW'(DEPTH))));

endmodule

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
// Instruction-fetch stage: owns the PC, issues in-order word requests to
// instruction memory under a credit limit, buffers returned words in a
// prefetch queue and hands {pc, instruction} to decode via valid/ready.
// Taken branches/jumps redirect the PC and discard stale responses.
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt   : request channel to instruction memory
//   imem_rvalid/imem_rdata        : in-order response channel
//   redirect_valid/redirect_pc    : taken branch/jump from downstream
//   inst_valid/inst_ready         : handshake to decode
//   inst_data/inst_pc             : head instruction and its byte address
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           imem_req,
  output logic [ADDR_W-1:0]              imem_addr,
  input  logic                           imem_gnt,
  input  logic                           imem_rvalid,
  input  logic [mips_pkg::INSTR_W-1:0]   imem_rdata,
  input  logic                           redirect_valid,
  input  logic [ADDR_W-1:0]              redirect_pc,
  output logic                           inst_valid,
  input  logic                           inst_ready,
  output logic [mips_pkg::INSTR_W-1:0]   inst_data,
  output logic [ADDR_W-1:0]              inst_pc
);

  import mips_pkg::*;

  localparam int unsigned CW     = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned PKG_AW = mips_pkg::ADDR_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(QUEUE_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] START_PC   = ADDR_W'(RESET_PC) & ALIGN_MASK;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;

  logic [CW-1:0]     q_count;
  logic [CW:0]       credit_used;
  logic              grant;
  logic              rsp_drop;
  logic              rsp_push;
  logic [ADDR_W-1:0] target_pc;
  logic              head_valid;
  fetch_entry_t      head_entry;
  fetch_entry_t      push_entry;

  // Queued entries plus in-flight requests may never exceed the queue size,
  // so every response that is kept is guaranteed a slot.
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding_q};

  // Gated by reset so the request drops the moment reset is asserted.
  assign imem_req  = reset && (credit_used < DEPTH_C) && !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  assign rsp_drop  = imem_rvalid && (discard_q != '0);
  assign rsp_push  = imem_rvalid && (discard_q == '0);

  assign target_pc = redirect_pc & ALIGN_MASK;

  assign push_entry.pc    = PKG_AW'(ret_pc_q);
  assign push_entry.instr = imem_rdata;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    ret_pc_d      = ret_pc_q;
    discard_d     = discard_q;
    // Outstanding only ever drops on a response, which is what lets
    // back-to-back redirects keep an exact discard count.
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
    if (rsp_push) begin
      ret_pc_d = ret_pc_q + ADDR_W'(4);
    end
    if (rsp_drop) begin
      discard_d = discard_q - CW'(1);
    end

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      ret_pc_d   = target_pc;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= START_PC;
      ret_pc_q      <= START_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      ret_pc_q      <= ret_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_ni       (reset),
    .flush_i      (redirect_valid),
    .push_i       (rsp_push),
    .push_data_i  (push_entry),
    .pop_i        (inst_ready),
    .head_valid_o (head_valid),
    .head_data_o  (head_entry),
    .count_o      (q_count)
  );

  assign inst_valid = head_valid;
  assign inst_data  = head_entry.instr;
  assign inst_pc    = ADDR_W'(head_entry.pc);

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (DEPTH),
    .ADDR_W      (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // Contents of instruction memory: distinct word per address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- memory model: in-order, fixed latency ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) mq.delete();
      else if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: cyc + lat});
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  // path_q: pcs of requests on the current path, oldest first (queued or in flight)
  // arrived: how many of those have returned; stale: old-path responses still due
  logic [31:0] path_q[$];
  int          arrived = 0;
  int          stale   = 0;
  logic [31:0] next_pc = 32'h0;
  logic        m_req;
  logic        m_valid;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_valid", {31'b0, inst_valid}, 32'd0);
        path_q.delete();
        arrived = 0;
        stale   = 0;
        next_pc = 32'h0;
      end else begin
        m_req   = (path_q.size() + stale < DEPTH) && !redirect_valid;
        m_valid = (arrived > 0);
        chk("model_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req && imem_req) chk("model_addr", imem_addr, next_pc);
        chk("model_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        if (m_valid && inst_valid) begin
          chk("model_pc", inst_pc, path_q[0]);
          chk("model_data", inst_data, word_at(path_q[0]));
        end
        if (m_valid && inst_ready) begin
          void'(path_q.pop_front());
          arrived--;
        end
        if (imem_rvalid) begin
          if (stale > 0) stale--;
          else if (arrived < path_q.size()) arrived++;
          else begin
            n_checks++;
            n_errors++;
            $display("FAIL model_rsp: got response with %0d outstanding, expected none", path_q.size() - arrived);
          end
        end
        if (m_req && imem_gnt) begin
          path_q.push_back(next_pc);
          next_pc += 32'd4;
        end
        if (redirect_valid) begin
          stale  += path_q.size() - arrived;
          path_q.delete();
          arrived = 0;
          next_pc = redirect_pc & ~32'h3;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset(input logic rdy, input int l);
    @(posedge clk); #1;
    reset          = 1'b0;
    inst_ready     = rdy;
    imem_gnt       = 1'b1;
    redirect_valid = 1'b0;
    lat            = l;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        found = 1'b1;
        chk(name, inst_pc, exp_pc);
      end
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no pop within 40 cycles, expected pc %08h", name, exp_pc);
    end
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] bp_exp [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
  logic [31:0] tgt    [2] = '{32'h40, 32'h43};

  initial begin
    int n_req;
    reset          = 1'b0;
    imem_gnt       = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);

    // Straight-line fetch, latency 1
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("sl_c1_addr", imem_addr, 32'h0);
    chk("sl_c1_req", {31'b0, imem_req}, 32'd1);
    chk("sl_c1_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("sl_c2_addr", imem_addr, 32'h4);
    chk("sl_c2_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("sl_c3_valid", {31'b0, inst_valid}, 32'd1);
    chk("sl_c3_pc", inst_pc, 32'h0);
    chk("sl_c3_data", inst_data, 32'hA5A5_0F0F);
    chk("sl_c3_addr", imem_addr, 32'h8);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("sl_stream_valid", {31'b0, inst_valid}, 32'd1);
      chk("sl_stream_pc", inst_pc, 32'(4 * i));
    end

    // Backpressure: decode stalled for 10 cycles
    apply_reset(1'b0, 1);
    n_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req && imem_gnt) n_req++;
    end
    chk("bp_req_count", 32'(n_req), 32'd4);
    chk("bp_req_low", {31'b0, imem_req}, 32'd0);
    chk("bp_head_valid", {31'b0, inst_valid}, 32'd1);
    chk("bp_head_pc", inst_pc, 32'h0);
    @(posedge clk); #1; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_pop("bp_pop_pc", bp_exp[i]);

    // Redirect with two fetches in flight, latency 3
    for (int t = 0; t < 2; t++) begin
      apply_reset(1'b1, 3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      imem_gnt       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = tgt[t];
      @(negedge clk);
      chk("rd_req_suppressed", {31'b0, imem_req}, 32'd0);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      imem_gnt       = 1'b1;
      @(negedge clk);
      chk("rd_n1_req", {31'b0, imem_req}, 32'd1);
      chk("rd_n1_addr", imem_addr, 32'h40);
      chk("rd_n1_valid", {31'b0, inst_valid}, 32'd0);
      wait_pop("rd_first_pc", 32'h40);
      chk("rd_first_data", inst_data, 32'hA5A5_0F4F);
      wait_pop("rd_second_pc", 32'h44);
    end

    // Redirect coincident with a pop and a response
    apply_reset(1'b1, 1);
    repeat (4) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("co_pop_and_rsp", {31'b0, inst_valid && inst_ready && imem_rvalid}, 32'd1);
    chk("co_popped_pc", inst_pc, 32'h8);
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    chk("co_flushed", {31'b0, inst_valid}, 32'd0);
    wait_pop("co_target_pc", 32'h100);

    // PC wrap at the top of the address space
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    inst_ready     = 1'b0;
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr2", imem_addr, 32'h0000_0000);
    @(posedge clk); #1; inst_ready = 1'b1;
    wait_pop("wrap_pc0", 32'hFFFF_FFF8);
    wait_pop("wrap_pc1", 32'hFFFF_FFFC);
    wait_pop("wrap_pc2", 32'h0000_0000);

    // Asynchronous reset mid-burst: 1 queued, 3 outstanding
    apply_reset(1'b0, 4);
    repeat (5) @(posedge clk);
    #2;
    chk("arst_pre_valid", {31'b0, inst_valid}, 32'd1);
    #1; reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_pc", inst_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b1;
    inst_ready = 1'b1;
    lat        = 1;
    @(negedge clk);
    chk("arst_restart_req", {31'b0, imem_req}, 32'd1);
    chk("arst_restart_addr", imem_addr, 32'h0);
    wait_pop("arst_first_pc", 32'h0);
    wait_pop("arst_second_pc", 32'h4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no completion by 50000, expected $finish earlier");
    $fatal(1);
  end

endmodule
